mem_arbiter: RTL and testbench

Single owner of the byte-wide RAM/IO port. It is shared between the instruction cache (word refill on miss) and the load/store buffer (byte/half/word loads and stores). It serialises each request into byte transfers and returns the assembled data with a one-cycle ready pulse. It aborts speculative work on pipeline flush and throttles IO writes on io_buffer_full.

---
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-wide RAM/IO port.
//
// Two requesters share the port: the instruction cache (fixed-length word
// refill) and the load/store buffer (byte/half/word loads and stores). An
// accepted request is serialised into single-byte bus transfers. The
// assembled little-endian result is returned with a one-cycle ready pulse.
//
// Ports
//   clk_in, rst_in        clock (rising edge), asynchronous active-high reset
//   rdy_in                global enable; low freezes every register
//   need_flush_in         pipeline flush: aborts reads, lets stores finish
//   io_buffer_full        holds off stores to the IO window
//   mem_din/mem_dout      RAM read byte (one cycle after its address) / write byte
//   mem_a, mem_wr         RAM byte address and write strobe
//   ic_req_*/ic_ready/ic_data       icache refill request and response
//   lsb_req_*/lsb_ready/lsb_data    load/store request and response
module mem_arbiter #(
    parameter logic [31:0] IO_BASE  = 32'h00030000,
    parameter int          IC_BYTES = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        need_flush_in,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        ic_req_valid,
    input  logic [31:0] ic_req_addr,
    output logic        ic_ready,
    output logic [31:0] ic_data,
    input  logic        lsb_req_valid,
    input  logic        lsb_req_wr,
    input  logic [31:0] lsb_req_addr,
    input  logic [1:0]  lsb_req_width,
    input  logic [31:0] lsb_req_data,
    output logic        lsb_ready,
    output logic [31:0] lsb_data
);

    typedef enum logic [2:0] {IDLE, IC_RD, LSB_RD, LSB_WR, DONE} state_t;
    typedef enum logic [1:0] {K_IC, K_LD, K_ST} kind_t;

    typedef struct packed {
        kind_t       kind;
        logic [31:0] addr;
        logic [2:0]  len;   // byte count, 1..4
        logic [31:0] data;  // store data
    } req_t;

    state_t      state;
    req_t        req;
    logic [2:0]  cnt;       // active edges since acceptance
    logic [31:0] rd_buf;
    logic        ic_ready_q;
    logic        lsb_ready_q;
    logic        stalled;   // previous edge was frozen by rdy_in
    logic [7:0]  din_save;  // read byte that was due at the first frozen edge

    logic        lsb_io_st;
    logic        lsb_go;
    logic        ic_go;
    logic [2:0]  lsb_len;
    logic [7:0]  byte_in;
    logic [7:0]  wr_byte;
    logic [1:0]  cap_sh;
    logic [31:0] rd_buf_nxt;

    always_comb begin
        lsb_io_st = lsb_req_wr && (lsb_req_addr[17:16] == IO_BASE[17:16]);
        // An IO store held off by a full buffer still blocks the icache.
        lsb_go    = lsb_req_valid && !(lsb_io_st && io_buffer_full);
        ic_go     = ic_req_valid && !lsb_req_valid;

        case (lsb_req_width)
            2'b00:   lsb_len = 3'd1;
            2'b01:   lsb_len = 3'd2;
            default: lsb_len = 3'd4;
        endcase

        // The RAM keeps answering during a freeze, so mem_din has moved on to
        // the held address by the time we resume; the byte that was due at the
        // first frozen edge was parked in din_save.
        byte_in    = stalled ? din_save : mem_din;
        // Byte k arrives two active edges after acceptance + k.
        cap_sh     = cnt[1:0] - 2'd2;
        rd_buf_nxt = rd_buf | ({24'd0, byte_in} << {cap_sh, 3'b000});

        case (cnt[1:0])
            2'd1:    wr_byte = req.data[15:8];
            2'd2:    wr_byte = req.data[23:16];
            2'd3:    wr_byte = req.data[31:24];
            default: wr_byte = req.data[7:0];
        endcase
    end

    // A flush seen while the read result is being presented withdraws it.
    // Stores are committed, so their ready is never withdrawn.
    assign ic_ready  = ic_ready_q && !need_flush_in;
    assign lsb_ready = lsb_ready_q && !(need_flush_in && req.kind == K_LD);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            req         <= '0;
            cnt         <= '0;
            rd_buf      <= '0;
            mem_a       <= '0;
            mem_wr      <= 1'b0;
            mem_dout    <= '0;
            ic_ready_q  <= 1'b0;
            lsb_ready_q <= 1'b0;
            ic_data     <= '0;
            lsb_data    <= '0;
            stalled     <= 1'b0;
            din_save    <= '0;
        end else if (!rdy_in) begin
            stalled <= 1'b1;
            if (!stalled) din_save <= mem_din;
        end else begin
            stalled <= 1'b0;
            case (state)
                IDLE: begin
                    mem_wr <= 1'b0;
                    if (!need_flush_in) begin
                        if (lsb_go) begin
                            req    <= '{kind: lsb_req_wr ? K_ST : K_LD, addr: lsb_req_addr,
                                        len: lsb_len, data: lsb_req_data};
                            cnt    <= 3'd1;
                            rd_buf <= '0;
                            mem_a  <= lsb_req_addr;
                            if (lsb_req_wr) begin
                                state    <= LSB_WR;
                                mem_wr   <= 1'b1;
                                mem_dout <= lsb_req_data[7:0];
                            end else begin
                                state <= LSB_RD;
                            end
                        end else if (ic_go) begin
                            req    <= '{kind: K_IC, addr: ic_req_addr,
                                        len: 3'(IC_BYTES), data: 32'd0};
                            cnt    <= 3'd1;
                            rd_buf <= '0;
                            mem_a  <= ic_req_addr;
                            state  <= IC_RD;
                        end
                    end
                end

                IC_RD, LSB_RD: begin
                    if (need_flush_in) begin
                        // Bytes still in flight from the RAM are simply ignored.
                        state  <= IDLE;
                        mem_wr <= 1'b0;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt < req.len) mem_a <= req.addr + {29'd0, cnt};
                        if (cnt >= 3'd2) rd_buf <= rd_buf_nxt;
                        if (cnt == req.len + 3'd1) begin
                            state <= DONE;
                            if (req.kind == K_IC) begin
                                ic_ready_q <= 1'b1;
                                ic_data    <= rd_buf_nxt;
                            end else begin
                                lsb_ready_q <= 1'b1;
                                lsb_data    <= rd_buf_nxt;
                            end
                        end
                    end
                end

                LSB_WR: begin
                    cnt <= cnt + 3'd1;
                    if (cnt < req.len) begin
                        mem_a    <= req.addr + {29'd0, cnt};
                        mem_dout <= wr_byte;
                    end else begin
                        mem_wr      <= 1'b0;
                        mem_a       <= '0;
                        state       <= DONE;
                        lsb_ready_q <= 1'b1;
                    end
                end

                DONE: begin
                    ic_ready_q  <= 1'b0;
                    lsb_ready_q <= 1'b0;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: byte RAM model, table of directed transfers,
// hand-written multi-cycle corner cases and a randomized run against a
// flat byte-array reference memory.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, need_flush_in, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_ready;
    logic [31:0] ic_data;
    logic        lsb_req_valid, lsb_req_wr;
    logic [31:0] lsb_req_addr;
    logic [1:0]  lsb_req_width;
    logic [31:0] lsb_req_data;
    logic        lsb_ready;
    logic [31:0] lsb_data;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0]  img   [0:65535];   // initial RAM image
    logic [7:0]  ram   [0:65535];   // RAM seen by the DUT
    logic [7:0]  model [0:65535];   // reference memory for the random run
    logic [39:0] wr_log [$];        // {addr, byte} of every write strobe
    logic        load_img = 1'b1;

    always #5 clk_in = ~clk_in;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .need_flush_in(need_flush_in), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
        .ic_ready(ic_ready), .ic_data(ic_data),
        .lsb_req_valid(lsb_req_valid), .lsb_req_wr(lsb_req_wr),
        .lsb_req_addr(lsb_req_addr), .lsb_req_width(lsb_req_width),
        .lsb_req_data(lsb_req_data), .lsb_ready(lsb_ready), .lsb_data(lsb_data)
    );

    // Synchronous byte RAM: data for the address sampled at an edge appears
    // after that edge. IO-window writes are only logged.
    always @(posedge clk_in) begin
        if (load_img) for (int i = 0; i < 65536; i++) ram[i] = img[i];
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr) begin
            wr_log.push_back({mem_a, mem_dout});
            if (mem_a[17:16] != 2'b11) ram[mem_a[15:0]] = mem_dout;
        end
    end

    typedef struct {
        bit          ic;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  w;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input bit ic, input logic [1:0] w);
        if (ic) return 4;
        case (w)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Called at a negedge; lat counts negedges until ready is seen (-1 on timeout).
    task automatic run_lsb(input bit wr, input logic [31:0] a, input logic [1:0] w,
                           input logic [31:0] d, output logic [31:0] rd, output int lat);
        lsb_req_wr = wr; lsb_req_addr = a; lsb_req_width = w; lsb_req_data = d;
        lsb_req_valid = 1'b1;
        lat = 0;
        do begin @(negedge clk_in); lat++; end while (!lsb_ready && lat < 60);
        rd = lsb_data;
        lsb_req_valid = 1'b0;
        if (!lsb_ready) lat = -1;
        else begin @(negedge clk_in); chk("lsb_pulse_width", {63'd0, lsb_ready}, 64'd0); end
    endtask

    task automatic run_ic(input logic [31:0] a, output logic [31:0] rd, output int lat);
        ic_req_addr = a; ic_req_valid = 1'b1;
        lat = 0;
        do begin @(negedge clk_in); lat++; end while (!ic_ready && lat < 60);
        rd = ic_data;
        ic_req_valid = 1'b0;
        if (!ic_ready) lat = -1;
        else begin @(negedge clk_in); chk("ic_pulse_width", {63'd0, ic_ready}, 64'd0); end
    endtask

    task automatic chk_writes(input string nm, input int base, input bit wr,
                              input logic [31:0] a, input int n, input logic [31:0] d);
        int got;
        got = wr_log.size() - base;
        chk($sformatf("%s_wcount", nm), 64'(got), wr ? 64'(n) : 64'd0);
        if (wr && got == n)
            for (int k = 0; k < n; k++)
                chk($sformatf("%s_wbyte%0d", nm, k), {24'd0, wr_log[base + k]},
                    {24'd0, a + 32'(k), d[8*k +: 8]});
    endtask

    task automatic do_vec(input string nm, input bit ic, input bit wr, input logic [31:0] a,
                          input logic [1:0] w, input logic [31:0] d, input logic [31:0] exp);
        logic [31:0] rd;
        int lat, n, base;
        base = wr_log.size();
        n = nbytes(ic, w);
        if (ic) run_ic(a, rd, lat);
        else    run_lsb(wr, a, w, d, rd, lat);
        chk($sformatf("%s_lat", nm), 64'(lat), wr ? 64'(n + 1) : 64'(n + 2));
        if (!wr) chk($sformatf("%s_data", nm), {32'd0, rd}, {32'd0, exp});
        chk_writes(nm, base, wr, a, n, d);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r1, r2, a, d, exp;
        logic [1:0]  w;
        int          l1, l2, base, n, seen;
        bit          ic, wr;

        rst_in = 1'b1; rdy_in = 1'b1; need_flush_in = 1'b0; io_buffer_full = 1'b0;
        ic_req_valid = 1'b0; ic_req_addr = '0;
        lsb_req_valid = 1'b0; lsb_req_wr = 1'b0; lsb_req_addr = '0;
        lsb_req_width = '0; lsb_req_data = '0;

        for (int i = 0; i < 65536; i++) img[i] = 8'h00;
        img[16'h0100] = 8'h13; img[16'h0101] = 8'h05;
        img[16'h0104] = 8'h93; img[16'h0106] = 8'h10;
        img[16'h0203] = 8'hF0; img[16'h0204] = 8'h34; img[16'h0205] = 8'h12;
        img[16'h0300] = 8'h78; img[16'h0301] = 8'h56; img[16'h0302] = 8'h34; img[16'h0303] = 8'h12;
        img[16'hFFFE] = 8'hAB; img[16'hFFFF] = 8'h11;
        img[16'h0000] = 8'h22; img[16'h0001] = 8'h33; img[16'h0002] = 8'h44;
        for (int i = 16'h1000; i < 16'h2004; i++) img[i] = 8'($urandom);
        for (int i = 0; i < 65536; i++) model[i] = img[i];

        //            ic wr addr            w      data           expected
        vt[0]  = '{1, 0, 32'h0000_0100, 2'b10, 32'h0,         32'h0000_0513};
        vt[1]  = '{0, 0, 32'h0000_0203, 2'b00, 32'h0,         32'h0000_00F0};
        vt[2]  = '{0, 0, 32'h0000_0204, 2'b01, 32'h0,         32'h0000_1234};
        vt[3]  = '{0, 1, 32'h0000_0400, 2'b10, 32'hDEADBEEF,  32'h0};
        vt[4]  = '{0, 0, 32'h0000_0400, 2'b10, 32'h0,         32'hDEADBEEF};
        vt[5]  = '{0, 1, 32'h0000_0402, 2'b01, 32'h0000_AABB, 32'h0};
        vt[6]  = '{0, 1, 32'h0000_0401, 2'b00, 32'h1234_5677, 32'h0};
        vt[7]  = '{0, 0, 32'h0000_0400, 2'b10, 32'h0,         32'hAABB77EF};
        vt[8]  = '{0, 0, 32'h0000_0400, 2'b11, 32'h0,         32'hAABB77EF};
        vt[9]  = '{0, 0, 32'h0000_0401, 2'b00, 32'h0,         32'h0000_0077};
        vt[10] = '{0, 0, 32'hFFFF_FFFF, 2'b10, 32'h0,         32'h4433_2211};
        vt[11] = '{1, 0, 32'hFFFF_FFFE, 2'b10, 32'h0,         32'h3322_11AB};
        vt[12] = '{0, 0, 32'h0000_0402, 2'b01, 32'h0,         32'h0000_AABB};

        // Reset state
        repeat (2) @(negedge clk_in);
        chk("rst_mem_a", {32'd0, mem_a}, 64'd0);
        chk("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
        chk("rst_mem_dout", {56'd0, mem_dout}, 64'd0);
        chk("rst_readys", {62'd0, ic_ready, lsb_ready}, 64'd0);
        chk("rst_data", {ic_data, lsb_data}, 64'd0);
        rst_in = 1'b0;
        load_img = 1'b0;
        @(negedge clk_in);

        for (int i = 0; i < 13; i++)
            do_vec($sformatf("vec%0d", i), vt[i].ic, vt[i].wr, vt[i].addr, vt[i].w, vt[i].d, vt[i].exp);

        // Both requesters at once: LSB first, icache right after.
        fork
            run_lsb(1'b0, 32'h203, 2'b00, 32'h0, r1, l1);
            run_ic(32'h100, r2, l2);
        join
        chk("prio_lsb_lat", 64'(l1), 64'd3);
        chk("prio_lsb_data", {32'd0, r1}, 64'hF0);
        chk("prio_ic_lat", 64'(l2), 64'd10);
        chk("prio_ic_data", {32'd0, r2}, 64'h513);

        // Flush during an icache refill, before byte 2 is issued.
        ic_req_addr = 32'h100; ic_req_valid = 1'b1;
        repeat (2) @(negedge clk_in);
        need_flush_in = 1'b1; ic_req_valid = 1'b0;
        @(negedge clk_in);
        need_flush_in = 1'b0;
        chk("flush_ic_mem_wr", {63'd0, mem_wr}, 64'd0);
        seen = 0;
        repeat (10) begin @(negedge clk_in); if (ic_ready) seen++; end
        chk("flush_ic_no_ready", 64'(seen), 64'd0);
        do_vec("after_flush_ic", 1'b1, 1'b0, 32'h104, 2'b10, 32'h0, 32'h0010_0093);

        // Flush during a store: store completes.
        base = wr_log.size();
        fork
            run_lsb(1'b1, 32'h500, 2'b10, 32'hCAFEF00D, r1, l1);
            begin
                repeat (2) @(negedge clk_in);
                need_flush_in = 1'b1;
                @(negedge clk_in);
                need_flush_in = 1'b0;
            end
        join
        chk("flush_st_lat", 64'(l1), 64'd5);
        chk_writes("flush_st", base, 1'b1, 32'h500, 4, 32'hCAFEF00D);
        do_vec("flush_st_rb", 1'b0, 1'b0, 32'h500, 2'b10, 32'h0, 32'hCAFEF00D);

        // Flush in IDLE holds off acceptance.
        need_flush_in = 1'b1;
        fork
            run_lsb(1'b0, 32'h203, 2'b00, 32'h0, r1, l1);
            begin repeat (2) @(negedge clk_in); need_flush_in = 1'b0; end
        join
        chk("flush_idle_lat", 64'(l1), 64'd5);
        chk("flush_idle_data", {32'd0, r1}, 64'hF0);

        // IO store stalled by a full buffer; a waiting icache must not sneak in.
        io_buffer_full = 1'b1;
        base = wr_log.size();
        fork
            run_lsb(1'b1, 32'h0003_0000, 2'b00, 32'h5A, r1, l1);
            run_ic(32'h104, r2, l2);
            begin
                repeat (5) begin @(negedge clk_in); chk("io_stall_mem_wr", {63'd0, mem_wr}, 64'd0); end
                io_buffer_full = 1'b0;
            end
        join
        chk("io_st_lat", 64'(l1), 64'd7);
        chk_writes("io_st", base + 0, 1'b1, 32'h0003_0000, 1, 32'h5A);
        chk("io_ic_lat", 64'(l2), 64'd14);
        chk("io_ic_data", {32'd0, r2}, 64'h0010_0093);

        // rdy_in low for three edges in the middle of a word load.
        fork
            run_lsb(1'b0, 32'h300, 2'b10, 32'h0, r1, l1);
            begin
                repeat (2) @(negedge clk_in);
                rdy_in = 1'b0;
                repeat (3) begin @(negedge clk_in); chk("freeze_mem_a", {32'd0, mem_a}, 64'h301); end
                rdy_in = 1'b1;
            end
        join
        chk("freeze_lat", 64'(l1), 64'd9);
        chk("freeze_data", {32'd0, r1}, 64'h1234_5678);

        // Randomized traffic against the reference memory.
        for (int t = 0; t < 60; t++) begin
            ic = ($urandom_range(0, 9) < 2);
            wr = ic ? 1'b0 : 1'($urandom_range(0, 1));
            w  = 2'($urandom_range(0, 3));
            a  = 32'h1000 + 32'($urandom_range(0, 4095));
            if (ic) a[0] = 1'b0;
            d  = $urandom;
            n  = nbytes(ic, w);
            exp = '0;
            for (int k = 0; k < n; k++) begin
                if (wr) model[16'(a + 32'(k))] = d[8*k +: 8];
                else    exp[8*k +: 8] = model[16'(a + 32'(k))];
            end
            do_vec($sformatf("rnd%0d", t), ic, wr, a, w, d, exp);
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
        end

        // Reset in the middle of a refill: outputs clear, no ready follows.
        ic_req_addr = 32'h100; ic_req_valid = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("midrst_mem_a", {32'd0, mem_a}, 64'd0);
        chk("midrst_data", {ic_data, lsb_data}, 64'd0);
        ic_req_valid = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        seen = 0;
        repeat (10) begin @(negedge clk_in); if (ic_ready || lsb_ready) seen++; end
        chk("midrst_no_ready", 64'(seen), 64'd0);
        do_vec("after_rst", 1'b0, 1'b0, 32'h204, 2'b01, 32'h0, 32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
